video_pattern_gen: RTL and testbench



---
 rtl/video_pattern_gen_pkg.sv | 40 ++++
 rtl/video_timing_counter.sv | 65 ++++++
 rtl/video_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_video_pattern_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the test-pattern source: pattern codes, FSM states,
// the colour-bar palette and sync polarity helpers.
package video_pattern_gen_pkg;

  localparam logic [7:0] PAT_BLACK   = 8'd0;
  localparam logic [7:0] PAT_BARS    = 8'd1;
  localparam logic [7:0] PAT_RAMP    = 8'd2;
  localparam logic [7:0] PAT_CHECKER = 8'd3;
  localparam logic [7:0] PAT_SOLID   = 8'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  // Standard colour-bar order, left to right, as 24-bit RGB.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

  function automatic logic sync_idle(input logic pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters with active/sync region decode and frame strobes.
module video_timing_counter #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HW       = 12,
  parameter int VW       = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] h_lsb,
  output logic       v_checker,
  output logic       active,
  output logic       hs_act,
  output logic       vs_act,
  output logic       line_last,
  output logic       frame_first,
  output logic       frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (advance) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 1'b1;
      end
    end
  end

  assign h_lsb       = h_cnt_reg[7:0];
  assign v_checker   = v_cnt_reg[3];
  assign active      = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
  assign hs_act      = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
  assign vs_act      = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
  assign line_last   = (h_cnt_reg == H_LAST);
  assign frame_first = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign frame_last  = line_last && (v_cnt_reg == V_LAST);

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: run/idle control, per-frame pattern latch,
// pattern mux and registered vs/hs/de/rgb outputs.
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_i,
  input  logic [7:0] pattern_i,
  input  logic [7:0] solid_r_i,
  input  logic [7:0] solid_g_i,
  input  logic [7:0] solid_b_i,
  output logic       vs_o,
  output logic       hs_o,
  output logic       de_o,
  output logic [7:0] rgb_r_o,
  output logic [7:0] rgb_g_o,
  output logic [7:0] rgb_b_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW      = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic HS_P = 1'(HS_POL);
  localparam logic VS_P = 1'(VS_POL);

  gen_state_t state_reg, state_next;
  logic       go;
  logic [7:0] h_lsb;
  logic       v_checker, active, hs_act, vs_act, line_last, frame_first, frame_last;

  logic [7:0]    pattern_reg;
  logic [23:0]   solid_reg;
  logic [BW-1:0] bar_pix_reg;
  logic [2:0]    bar_idx_reg;
  logic [7:0]    cur_pattern;
  logic [23:0]   cur_solid;
  logic [23:0]   pix;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clock(clock), .reset(reset), .advance(go),
    .h_lsb(h_lsb), .v_checker(v_checker), .active(active),
    .hs_act(hs_act), .vs_act(vs_act), .line_last(line_last),
    .frame_first(frame_first), .frame_last(frame_last)
  );

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Position (0,0) is emitted on the very clock enable is seen in IDLE, so a
  // restart produces frame_start_o one clock after enable_i rises.
  always_comb begin
    state_next = state_reg;
    go         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable_i) begin
          state_next = RUN;
          go         = 1'b1;
        end
      end
      RUN: begin
        go = 1'b1;
        if (frame_last && !enable_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_reg <= PAT_BLACK;
      solid_reg   <= '0;
    end else if (go && frame_first) begin
      pattern_reg <= pattern_i;
      solid_reg   <= {solid_r_i, solid_g_i, solid_b_i};
    end
  end

  // Bar position tracks h_cnt with a small counter instead of dividing it.
  always_ff @(posedge clock) begin
    if (reset) begin
      bar_pix_reg <= '0;
      bar_idx_reg <= '0;
    end else if (go) begin
      if (line_last) begin
        bar_pix_reg <= '0;
        bar_idx_reg <= '0;
      end else if (bar_pix_reg == BAR_LAST) begin
        bar_pix_reg <= '0;
        bar_idx_reg <= bar_idx_reg + 1'b1;
      end else begin
        bar_pix_reg <= bar_pix_reg + 1'b1;
      end
    end
  end

  // The first pixel of a frame is rendered from the values being latched now.
  always_comb begin
    cur_pattern = frame_first ? pattern_i : pattern_reg;
    cur_solid   = frame_first ? {solid_r_i, solid_g_i, solid_b_i} : solid_reg;
    pix         = 24'h000000;
    case (cur_pattern)
      PAT_BARS:    pix = bar_color(bar_idx_reg);
      PAT_RAMP:    pix = {3{h_lsb}};
      PAT_CHECKER: pix = {24{h_lsb[3] ^ v_checker}};
      PAT_SOLID:   pix = cur_solid;
      default:     pix = 24'h000000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !go) begin
      de_o          <= 1'b0;
      hs_o          <= sync_idle(HS_P);
      vs_o          <= sync_idle(VS_P);
      rgb_r_o       <= '0;
      rgb_g_o       <= '0;
      rgb_b_o       <= '0;
      frame_start_o <= 1'b0;
    end else begin
      de_o          <= active;
      hs_o          <= sync_level(hs_act, HS_P);
      vs_o          <= sync_level(vs_act, VS_P);
      {rgb_r_o, rgb_g_o, rgb_b_o} <= active ? pix : 24'h000000;
      frame_start_o <= frame_first;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 24x8 raster (16x4 active).
module tb_video_pattern_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable_i;
  logic [7:0] pattern_i, solid_r_i, solid_g_i, solid_b_i;
  logic       vs_o, hs_o, de_o, frame_start_o;
  logic [7:0] rgb_r_o, rgb_g_o, rgb_b_o;

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1)
  ) dut (
    .clock(clock), .reset(reset), .enable_i(enable_i), .pattern_i(pattern_i),
    .solid_r_i(solid_r_i), .solid_g_i(solid_g_i), .solid_b_i(solid_b_i),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o),
    .rgb_r_o(rgb_r_o), .rgb_g_o(rgb_g_o), .rgb_b_o(rgb_b_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  pat;
    logic [23:0] solid;
    int          v;
    int          h;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_pos = 0;

  function automatic vec_t mk(logic [7:0] pat, logic [23:0] solid, int v, int h,
                              logic de, logic hs, logic vs, logic [23:0] rgb);
    vec_t r;
    r.pat = pat; r.solid = solid; r.v = v; r.h = h;
    r.exp = {de, hs, vs, rgb};
    return r;
  endfunction

  function automatic logic [26:0] outs();
    return {de_o, hs_o, vs_o, rgb_r_o, rgb_g_o, rgb_b_o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic goto_pos(int target);
    step(target - cur_pos);
    cur_pos = target;
  endtask

  // Leaves the bench on the negedge showing pixel (0,0) of the next frame.
  task automatic sync_frame(string name);
    bit found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clock);
      if (frame_start_o) found = 1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: frame_start_o not seen within 500 clocks", name);
    end
    cur_pos = 0;
  endtask

  task automatic set_solid(logic [23:0] s);
    {solid_r_i, solid_g_i, solid_b_i} = s;
  endtask

  initial begin
    int cnt_de, cnt_hs, cnt_vs, cnt_fs, target;
    logic [7:0]  last_pat;
    logic [23:0] last_solid;

    // Pattern 0 timing
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 15, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 17, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 18, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 20, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 21, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 5, 0,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 6, 19, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 6, 23, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 7, 0,  0, 0, 0, 0));
    // Colour bars, 2 pixels each
    vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 24'hFFFFFF));
    vecs.push_back(mk(1, 0, 0, 1,  1, 0, 0, 24'hFFFFFF));
    vecs.push_back(mk(1, 0, 0, 2,  1, 0, 0, 24'hFFFF00));
    vecs.push_back(mk(1, 0, 0, 10, 1, 0, 0, 24'hFF0000));
    vecs.push_back(mk(1, 0, 0, 13, 1, 0, 0, 24'h0000FF));
    vecs.push_back(mk(1, 0, 0, 14, 1, 0, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 0, 17, 0, 0, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 1, 0,  1, 0, 0, 24'hFFFFFF));
    vecs.push_back(mk(1, 0, 1, 5,  1, 0, 0, 24'h00FFFF));
    vecs.push_back(mk(1, 0, 2, 6,  1, 0, 0, 24'h00FF00));
    vecs.push_back(mk(1, 0, 3, 9,  1, 0, 0, 24'hFF00FF));
    // Ramp
    vecs.push_back(mk(2, 0, 0, 0,  1, 0, 0, 24'h000000));
    vecs.push_back(mk(2, 0, 0, 5,  1, 0, 0, 24'h050505));
    vecs.push_back(mk(2, 0, 0, 16, 0, 0, 0, 24'h000000));
    vecs.push_back(mk(2, 0, 3, 15, 1, 0, 0, 24'h0F0F0F));
    // Checkerboard
    vecs.push_back(mk(3, 0, 0, 7,  1, 0, 0, 24'h000000));
    vecs.push_back(mk(3, 0, 0, 8,  1, 0, 0, 24'hFFFFFF));
    vecs.push_back(mk(3, 0, 2, 15, 1, 0, 0, 24'hFFFFFF));
    vecs.push_back(mk(3, 0, 3, 3,  1, 0, 0, 24'h000000));
    // Solid colour and unknown codes
    vecs.push_back(mk(4, 24'h64C810, 0, 0,  1, 0, 0, 24'h64C810));
    vecs.push_back(mk(4, 24'h64C810, 1, 16, 0, 0, 0, 24'h000000));
    vecs.push_back(mk(4, 24'h64C810, 3, 15, 1, 0, 0, 24'h64C810));
    vecs.push_back(mk(7, 24'h64C810, 0, 4,  1, 0, 0, 24'h000000));
    vecs.push_back(mk(5, 24'hFFFFFF, 1, 1,  1, 0, 0, 24'h000000));

    reset = 1'b1;
    enable_i = 1'b0;
    pattern_i = 8'd0;
    set_solid(24'h0);
    step(3);
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_frame_start", 32'(frame_start_o), 32'd0);

    reset = 1'b0;
    step(5);
    check("idle_no_start", 32'({frame_start_o, de_o}), 32'd0);
    enable_i = 1'b1;
    step(1);
    check("first_enable_start", 32'(frame_start_o), 32'd1);

    last_pat = 8'hFF;
    last_solid = 24'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      target = vecs[i].v * 24 + vecs[i].h;
      if (vecs[i].pat != last_pat || vecs[i].solid != last_solid || target <= cur_pos) begin
        pattern_i = vecs[i].pat;
        set_solid(vecs[i].solid);
        last_pat = vecs[i].pat;
        last_solid = vecs[i].solid;
        sync_frame($sformatf("vec%0d_sync", i));
      end
      goto_pos(target);
      check($sformatf("vec%0d_p%0d_v%0d_h%0d", i, vecs[i].pat, vecs[i].v, vecs[i].h),
            32'(outs()), 32'(vecs[i].exp));
    end

    // Whole-frame counts and frame period
    pattern_i = 8'd0;
    sync_frame("period_sync");
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    for (int k = 0; k < 192; k++) begin
      cnt_de += int'(de_o);
      cnt_hs += int'(hs_o);
      cnt_vs += int'(vs_o);
      cnt_fs += int'(frame_start_o);
      step(1);
    end
    check("frame_de_count", 32'(cnt_de), 32'd64);
    check("frame_hs_count", 32'(cnt_hs), 32'd24);
    check("frame_vs_count", 32'(cnt_vs), 32'd48);
    check("frame_start_count", 32'(cnt_fs), 32'd1);
    check("frame_period_192", 32'(frame_start_o), 32'd1);

    // Ramp frame, pattern changed mid-frame to checkerboard
    pattern_i = 8'd2;
    sync_frame("ramp_sync");
    goto_pos(24);
    pattern_i = 8'd3;
    goto_pos(2 * 24 + 5);
    check("ramp_hold_mid", 32'(outs()), 32'({3'b100, 24'h050505}));
    goto_pos(3 * 24 + 15);
    check("ramp_hold_end", 32'(outs()), 32'({3'b100, 24'h0F0F0F}));
    sync_frame("checker_sync");
    check("checker_px0", 32'(outs()), 32'({3'b100, 24'h000000}));
    goto_pos(8);
    check("checker_px8", 32'(outs()), 32'({3'b100, 24'hFFFFFF}));

    // Solid colour changed mid-frame
    pattern_i = 8'd4;
    set_solid(24'h64C810);
    sync_frame("solid_sync");
    goto_pos(24);
    set_solid(24'h112233);
    goto_pos(3 * 24 + 15);
    check("solid_hold", 32'(outs()), 32'({3'b100, 24'h64C810}));
    sync_frame("solid_next_sync");
    check("solid_next", 32'(outs()), 32'({3'b100, 24'h112233}));

    // enable dropped at line 2: frame completes, then idle
    pattern_i = 8'd0;
    sync_frame("drop_sync");
    goto_pos(48);
    enable_i = 1'b0;
    goto_pos(3 * 24 + 15);
    check("drop_still_active", 32'(de_o), 32'd1);
    goto_pos(6 * 24 + 2);
    check("drop_vs_line6", 32'(vs_o), 32'd1);
    goto_pos(192);
    check("drop_idle_outputs", 32'({frame_start_o, outs()}), 32'd0);
    cnt_fs = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      cnt_fs += int'(frame_start_o | de_o | hs_o | vs_o);
    end
    check("drop_idle_quiet", 32'(cnt_fs), 32'd0);
    enable_i = 1'b1;
    step(1);
    check("reenable_start", 32'({frame_start_o, de_o}), 32'b11);

    // Reset in the middle of an active line
    sync_frame("reset_sync");
    goto_pos(5);
    reset = 1'b1;
    enable_i = 1'b0;
    step(1);
    check("midreset_outputs", 32'({frame_start_o, outs()}), 32'd0);
    reset = 1'b0;
    cnt_fs = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      cnt_fs += int'(frame_start_o);
    end
    check("midreset_no_start", 32'(cnt_fs), 32'd0);
    enable_i = 1'b1;
    step(1);
    check("midreset_restart", 32'(frame_start_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
